// File: rtl/bit_serial_alu_seq.sv
// Purpose: sequences one shared 1-bit ALU as a WIDTH-bit ALU, LSB first, with a carry chain.
// Latency: start accepted at edge E; done pulses in cycle E+WIDTH+1; idle again from E+WIDTH+2.
// Backpressure: none; start is only sampled in IDLE, so requests while busy are dropped.
module bit_serial_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    input  logic [2:0]       opsel_in,
    input  logic             mode_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             alu_op1,
    output logic             alu_op2,
    output logic             alu_cin,
    output logic [2:0]       alu_opsel,
    output logic             alu_mode,
    input  logic             alu_result,
    input  logic             alu_cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    // Operand bits not yet presented; bit 0 of each operand lives in alu_op1/alu_op2.
    logic [WIDTH-2:0] a_rest;
    logic [WIDTH-2:0] b_rest;
    // Result bits gathered so far (upper WIDTH-1 positions of the shift chain).
    logic [WIDTH-2:0] acc;
    logic [WIDTH-1:0] acc_next;

    // Current ALU result bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    assign acc_next = {alu_result, acc};

    // Sequencer FSM; alu_cin doubles as the carry register between bit slices.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            cnt       <= '0;
            a_rest    <= '0;
            b_rest    <= '0;
            acc       <= '0;
            alu_op1   <= 1'b0;
            alu_op2   <= 1'b0;
            alu_cin   <= 1'b0;
            alu_opsel <= 3'b000;
            alu_mode  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_rest    <= a_in[WIDTH-1:1];
                        b_rest    <= b_in[WIDTH-1:1];
                        alu_op1   <= a_in[0];
                        alu_op2   <= b_in[0];
                        alu_cin   <= cin_in;
                        alu_opsel <= opsel_in;
                        alu_mode  <= mode_in;
                        acc       <= '0;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc    <= acc_next[WIDTH-1:1];
                    a_rest <= a_rest >> 1;
                    b_rest <= b_rest >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        // Last slice: capture the word and park the operand pins at 0.
                        result  <= acc_next;
                        cout    <= alu_cout;
                        done    <= 1'b1;
                        alu_op1 <= 1'b0;
                        alu_op2 <= 1'b0;
                        alu_cin <= 1'b0;
                        state   <= S_DONE;
                    end else begin
                        alu_op1 <= a_rest[0];
                        alu_op2 <= b_rest[0];
                        alu_cin <= alu_cout;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// Bench for bit_serial_alu_seq with a 1-bit ALU stub (mode=1 full adder, mode=0 AND).
// Table vectors, hand-written reset sequences, then random additions against plain arithmetic.
module tb_bit_serial_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in, b_in;
    logic         cin_in;
    logic [2:0]   opsel_in;
    logic         mode_in;
    logic         busy, done;
    logic [W-1:0] result;
    logic         cout;
    logic         alu_op1, alu_op2, alu_cin;
    logic [2:0]   alu_opsel;
    logic         alu_mode;
    logic         alu_result, alu_cout;

    always #5 clk = ~clk;

    // 1-bit ALU stub
    assign alu_result = alu_mode ? (alu_op1 ^ alu_op2 ^ alu_cin) : (alu_op1 & alu_op2);
    assign alu_cout   = alu_mode ? ((alu_op1 & alu_op2) | (alu_op1 & alu_cin) | (alu_op2 & alu_cin)) : 1'b0;

    bit_serial_alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
        .opsel_in(opsel_in), .mode_in(mode_in), .busy(busy), .done(done), .result(result),
        .cout(cout), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_cin(alu_cin),
        .alu_opsel(alu_opsel), .alu_mode(alu_mode), .alu_result(alu_result), .alu_cout(alu_cout)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen = 0;
    int ops_done  = 0;
    logic [W-1:0] prev_res;
    logic         prev_cout;

    always @(negedge clk) if (done === 1'b1) done_seen++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // Called at a negedge while the DUT is idle; returns at the negedge of the first idle cycle after done.
    task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic [2:0] os, input logic md, input logic [W-1:0] er, input logic ec,
                          input bit disturb);
        logic [W-1:0] op1s, op2s;
        logic cin0;
        bit busy_ok, hold_ok, pins_ok;
        op1s = '0; op2s = '0; cin0 = 1'b0;
        busy_ok = 1'b1; hold_ok = 1'b1; pins_ok = 1'b1;
        start = 1'b1; a_in = a; b_in = b; cin_in = c; opsel_in = os; mode_in = md;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= W; k++) begin
            @(negedge clk);
            if (busy !== 1'b1 || done !== 1'b0) busy_ok = 1'b0;
            if (result !== prev_res || cout !== prev_cout) hold_ok = 1'b0;
            if (alu_opsel !== os || alu_mode !== md) pins_ok = 1'b0;
            op1s[k-1] = alu_op1;
            op2s[k-1] = alu_op2;
            if (k == 1) cin0 = alu_cin;
            if (disturb) begin
                a_in = W'($urandom); b_in = W'($urandom); cin_in = 1'($urandom);
                opsel_in = 3'($urandom); mode_in = 1'($urandom);
                start = (k == 3);
            end
        end
        @(negedge clk);
        start = 1'b0;
        check({nm, ".done"}, 32'(done), 32'd1);
        check({nm, ".busy_done"}, 32'(busy), 32'd1);
        check({nm, ".result"}, 32'(result), 32'(er));
        check({nm, ".cout"}, 32'(cout), 32'(ec));
        check({nm, ".pins_idle_done"}, 32'({alu_op1, alu_op2, alu_cin}), 32'd0);
        if (alu_opsel !== os || alu_mode !== md) pins_ok = 1'b0;
        check({nm, ".busy_run"}, 32'(busy_ok), 32'd1);
        check({nm, ".result_hold"}, 32'(hold_ok), 32'd1);
        check({nm, ".opsel_mode"}, 32'(pins_ok), 32'd1);
        check({nm, ".op1_seq"}, 32'(op1s), 32'(a));
        check({nm, ".op2_seq"}, 32'(op2s), 32'(b));
        check({nm, ".cin0"}, 32'(cin0), 32'(c));
        @(negedge clk);
        check({nm, ".idle_after"}, 32'({busy, done}), 32'd0);
        check({nm, ".result_kept"}, 32'({cout, result}), 32'({ec, er}));
        prev_res = er; prev_cout = ec;
        ops_done++;
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [2:0]   opsel;
        logic         mode;
        logic [W-1:0] res;
        logic         cout;
        bit           disturb;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [W:0] sum;
        bit no_done;
        int snap;

        vecs[0] = '{8'h3C, 8'h55, 1'b0, 3'b010, 1'b1, 8'h91, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 3'b000, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'h01, 1'b1, 3'b111, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[3] = '{8'hF0, 8'h3C, 1'b0, 3'b101, 1'b0, 8'h30, 1'b0, 1'b0};
        vecs[4] = '{8'h3C, 8'h55, 1'b0, 3'b011, 1'b1, 8'h91, 1'b0, 1'b1};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 3'b001, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{8'hAA, 8'h0F, 1'b1, 3'b100, 1'b0, 8'h0A, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; a_in = 8'hA5; b_in = 8'h5A; cin_in = 1'b1;
        opsel_in = 3'b111; mode_in = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.busy_done", 32'({busy, done}), 32'd0);
        check("reset.result", 32'({cout, result}), 32'd0);
        check("reset.pins", 32'({alu_op1, alu_op2, alu_cin, alu_opsel, alu_mode}), 32'd0);
        rst = 1'b0;
        prev_res = '0; prev_cout = 1'b0;

        // Table vectors, issued back to back
        for (int i = 0; i < 7; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].opsel,
                   vecs[i].mode, vecs[i].res, vecs[i].cout, vecs[i].disturb);

        // Reset in the middle of RUN
        snap = done_seen;
        start = 1'b1; a_in = 8'h77; b_in = 8'h11; cin_in = 1'b0; opsel_in = 3'b010; mode_in = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        check("midrun.busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrun.busy", 32'({busy, done}), 32'd0);
        check("midrun.result", 32'({cout, result}), 32'd0);
        check("midrun.pins", 32'({alu_op1, alu_op2, alu_cin, alu_opsel, alu_mode}), 32'd0);
        no_done = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) no_done = 1'b0;
        end
        check("midrun.no_done", 32'(no_done), 32'd1);
        check("midrun.done_count", 32'(done_seen), 32'(snap));
        prev_res = '0; prev_cout = 1'b0;

        // start and rst together: reset wins
        rst = 1'b1; start = 1'b1; a_in = 8'h01; b_in = 8'h01;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst_start.busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("rst_start.busy_next", 32'(busy), 32'd0);

        run_op("after_rst", 8'h12, 8'h34, 1'b0, 3'b110, 1'b1, 8'h46, 1'b0, 1'b0);

        // Random additions against plain arithmetic
        for (int i = 0; i < 200; i++) begin
            logic [W-1:0] ra, rb;
            logic rc;
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            sum = {1'b0, ra} + {1'b0, rb} + (W+1)'(rc);
            run_op($sformatf("rnd%0d", i), ra, rb, rc, 3'($urandom), 1'b1, sum[W-1:0], sum[W],
                   ($urandom_range(0, 3) == 0));
        end

        check("done_pulse_count", 32'(done_seen), 32'(ops_done));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
